// File: rtl/glm_model_store.sv
// Packs 32-bit model words into 512-bit BRAM lines, 16 lanes per line, lane 0 in the LSBs.
// Optional dropped-word counter port enabled by GLM_MODEL_STORE_DROPCNT_EN.
module glm_model_store #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  output logic                  op_done,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [31:0]           cfg_num_words,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_almostfull,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [511:0]          mem_wdata
`ifdef GLM_MODEL_STORE_DROPCNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic [31:0]           r_total;
  logic [31:0]           r_word_cnt;
  logic [3:0]            r_lane;
  logic [511:0]          r_buf;
  logic [511:0]          w_merged;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_line_done;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_merged     = r_buf;
    w_merged[{r_lane, 5'd0} +: 32] = in_data;
    w_last       = (r_word_cnt == r_total - 32'd1);
    w_line_done  = (r_lane == 4'd15) || w_last;
    case (r_state)
      IDLE: begin
        if (op_start) begin
          w_next_state = (cfg_num_words == 32'd0) ? DONE : PACK;
        end
      end
      PACK: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_next_state = DONE;
          end
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_line_addr   <= '0;
      r_total       <= '0;
      r_word_cnt    <= '0;
      r_lane        <= '0;
      r_buf         <= '0;
      op_done       <= 1'b0;
      in_almostfull <= 1'b1;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
    end else begin
      r_state       <= w_next_state;
      in_almostfull <= (w_next_state != PACK);
      mem_we        <= 1'b0;
      op_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (op_start) begin
            r_line_addr <= cfg_base;
            r_total     <= cfg_num_words;
            r_word_cnt  <= '0;
            r_lane      <= '0;
            r_buf       <= '0;
          end
        end
        PACK: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            // A line closes on lane 15 or on the final word; the buffer restarts
            // zeroed so a short last line carries zeros in its unused lanes.
            if (w_line_done) begin
              mem_we      <= 1'b1;
              mem_wdata   <= w_merged;
              mem_waddr   <= r_line_addr;
              r_line_addr <= r_line_addr + 1'b1;
              r_lane      <= '0;
              r_buf       <= '0;
            end else begin
              r_buf  <= w_merged;
              r_lane <= r_lane + 4'd1;
            end
          end
        end
        DONE:    op_done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef GLM_MODEL_STORE_DROPCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (r_state == IDLE && op_start) begin
      drop_count <= '0;
    end else if (in_valid && r_state != PACK && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_glm_model_store.sv
// Randomized bench for glm_model_store: expected BRAM lines are built from the word list
// and compared with the writes observed on the memory port.
module tb_glm_model_store;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_start;
  logic          op_done;
  logic [AW-1:0] cfg_base;
  logic [31:0]   cfg_num_words;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_almostfull;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [511:0]  mem_wdata;
`ifdef GLM_MODEL_STORE_DROPCNT_EN
  logic [15:0]   drop_count;
`endif

  glm_model_store #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_start      (op_start),
    .op_done       (op_done),
    .cfg_base      (cfg_base),
    .cfg_num_words (cfg_num_words),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_almostfull (in_almostfull),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata)
`ifdef GLM_MODEL_STORE_DROPCNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [511:0]  wr_data_q[$];
  int unsigned   wr_cyc_q[$];
  int unsigned   done_cyc_q[$];
  logic [31:0]   words[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_waddr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (op_done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each line of an operation holds words 16*line .. 16*line+15; missing words are zero.
  function automatic logic [511:0] exp_line(input int unsigned line, input int unsigned n);
    logic [511:0] l;
    l = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      if (line * 16 + j < n) l[j*32 +: 32] = words[line*16 + j];
    end
    return l;
  endfunction

  task automatic clear_monitor();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".op_done"}, op_done, 1'b0);
    check_eq({tag, ".mem_we"}, mem_we, 1'b0);
    check_eq({tag, ".mem_waddr"}, mem_waddr, '0);
    check_eq({tag, ".mem_wdata"}, mem_wdata, '0);
    check_eq({tag, ".almostfull"}, in_almostfull, 1'b1);
`ifdef GLM_MODEL_STORE_DROPCNT_EN
    check_eq({tag, ".drop_count"}, drop_count, 16'd0);
`endif
  endtask

  task automatic start_op(input int unsigned base, input int unsigned n, input bit rand_data,
                          output int unsigned s_cyc);
    words.delete();
    for (int unsigned i = 0; i < n; i++) words.push_back(rand_data ? 32'($urandom) : 32'(i));
    clear_monitor();
    cfg_base      = AW'(base);
    cfg_num_words = n;
    op_start      = 1'b1;
    @(negedge clk);
    op_start      = 1'b0;
    s_cyc         = cyc;
  endtask

  task automatic feed(input int unsigned n, input int unsigned gap_pct, output int unsigned k_cyc);
    int unsigned idx;
    int unsigned guard;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 10000) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = words[idx];
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    k_cyc    = cyc;
  endtask

  task automatic run_op(input string tag, input int unsigned base, input int unsigned n,
                        input int unsigned gap_pct, input bit rand_data);
    int unsigned s_cyc;
    int unsigned k_cyc;
    int unsigned nexp;
    start_op(base, n, rand_data, s_cyc);
    check_eq({tag, ".almostfull_start"}, in_almostfull, (n == 0) ? 1'b1 : 1'b0);
    k_cyc = s_cyc;
    if (n > 0) feed(n, gap_pct, k_cyc);
    repeat (6) @(negedge clk);
    nexp = (n + 15) / 16;
    check_eq({tag, ".nwrites"}, wr_addr_q.size(), nexp);
    for (int unsigned i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("%s.addr%0d", tag, i), wr_addr_q[i], (base + i) % (1 << AW));
      check_eq($sformatf("%s.data%0d", tag, i), wr_data_q[i], exp_line(i, n));
    end
    if (n > 0 && wr_cyc_q.size() > 0)
      check_eq({tag, ".last_write_cycle"}, wr_cyc_q[$], k_cyc);
    check_eq({tag, ".ndone"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0)
      check_eq({tag, ".done_cycle"}, done_cyc_q[0], (n == 0) ? s_cyc + 1 : k_cyc + 1);
    check_eq({tag, ".almostfull_end"}, in_almostfull, 1'b1);
`ifdef GLM_MODEL_STORE_DROPCNT_EN
    check_eq({tag, ".drop_count"}, drop_count, 16'd0);
`endif
  endtask

  initial begin
    int unsigned s_cyc;
    int unsigned k_cyc;
    reset         = 1'b1;
    op_start      = 1'b0;
    cfg_base      = '0;
    cfg_num_words = '0;
    in_valid      = 1'b0;
    in_data       = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

`ifdef GLM_MODEL_STORE_DROPCNT_EN
    clear_monitor();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("drop.count", drop_count, 16'd3);
    check_eq("drop.nwrites", wr_addr_q.size(), 0);
`endif

    run_op("b2b32", 4, 32, 0, 1'b0);
    run_op("part20", 0, 20, 0, 1'b1);
    run_op("zero", 0, 0, 0, 1'b0);
    run_op("gap32", 4, 32, 50, 1'b0);
    run_op("wrap", 1023, 32, 0, 1'b1);

    start_op(0, 16, 1'b1, s_cyc);
    feed(8, 0, k_cyc);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    check_eq("midreset.nwrites", wr_addr_q.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    run_op("after_reset", 0, 16, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      run_op($sformatf("rand%0d", t), $urandom_range(1023), $urandom_range(40, 1),
             $urandom_range(60), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
